video_sig_gen: RTL and testbench

- Free-running 720p raster timing generator.
- Sits directly upstream of the sprite renderers and the HDMI/TMDS encoder.
- Produces the hcount/vcount raster coordinates that sprite stages consume, plus hsync, vsync, active-draw, a new-frame strobe and a frame counter.
- All outputs are registered and mutually consistent on every cycle.

---
 rtl/video_timing_pkg.sv | 32 +++
 rtl/wrap_counter.sv | 25 ++
 rtl/video_sig_gen.sv | 93 +++++++++
 tb/tb_video_sig_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared 720p raster timing constants and coordinate types for the video pipeline.
package video_timing_pkg;

  localparam int unsigned ACTIVE_H_DEF      = 1280;
  localparam int unsigned H_FRONT_PORCH_DEF = 110;
  localparam int unsigned H_SYNC_WIDTH_DEF  = 40;
  localparam int unsigned H_BACK_PORCH_DEF  = 220;
  localparam int unsigned ACTIVE_LINES_DEF  = 720;
  localparam int unsigned V_FRONT_PORCH_DEF = 5;
  localparam int unsigned V_SYNC_WIDTH_DEF  = 5;
  localparam int unsigned V_BACK_PORCH_DEF  = 20;
  localparam int unsigned FPS_DEF           = 60;

  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 10;
  localparam int unsigned FC_W     = 6;

  typedef logic [HCOUNT_W-1:0] hcount_t;
  typedef logic [VCOUNT_W-1:0] vcount_t;
  typedef logic [FC_W-1:0]     fcount_t;

  function automatic int unsigned total_pixels(input int unsigned active, input int unsigned front,
                                               input int unsigned sync, input int unsigned back);
    return active + front + sync + back;
  endfunction

  function automatic int unsigned total_lines(input int unsigned active, input int unsigned front,
                                              input int unsigned sync, input int unsigned back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX counter that advances on incr_in; wrap_out flags the advance from MAX-1 back to 0.
module wrap_counter #(
  parameter int unsigned MAX   = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             incr_in,
  output logic [WIDTH-1:0] count_out,
  output logic             wrap_out
);

  assign wrap_out = incr_in && (count_out == WIDTH'(MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_out <= '0;
    end else if (wrap_out) begin
      count_out <= '0;
    end else if (incr_in) begin
      count_out <= count_out + WIDTH'(1);
    end
  end

endmodule

// File: rtl/video_sig_gen.sv
// Free-running raster timing generator: counts, syncs, active-draw, new-frame strobe, frame count.
module video_sig_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE_H      = ACTIVE_H_DEF,
  parameter int unsigned H_FRONT_PORCH = H_FRONT_PORCH_DEF,
  parameter int unsigned H_SYNC_WIDTH  = H_SYNC_WIDTH_DEF,
  parameter int unsigned H_BACK_PORCH  = H_BACK_PORCH_DEF,
  parameter int unsigned ACTIVE_LINES  = ACTIVE_LINES_DEF,
  parameter int unsigned V_FRONT_PORCH = V_FRONT_PORCH_DEF,
  parameter int unsigned V_SYNC_WIDTH  = V_SYNC_WIDTH_DEF,
  parameter int unsigned V_BACK_PORCH  = V_BACK_PORCH_DEF,
  parameter int unsigned FPS           = FPS_DEF
) (
  input  logic                pixel_clk_in,
  input  logic                rst_n_in,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                hs_out,
  output logic                vs_out,
  output logic                ad_out,
  output logic                nf_out,
  output logic [FC_W-1:0]     fc_out
);

  localparam int unsigned TOTAL_PIXELS =
    total_pixels(ACTIVE_H, H_FRONT_PORCH, H_SYNC_WIDTH, H_BACK_PORCH);
  localparam int unsigned TOTAL_LINES =
    total_lines(ACTIVE_LINES, V_FRONT_PORCH, V_SYNC_WIDTH, V_BACK_PORCH);
  localparam int unsigned HS_START = ACTIVE_H + H_FRONT_PORCH;
  localparam int unsigned HS_END   = HS_START + H_SYNC_WIDTH;
  localparam int unsigned VS_START = ACTIVE_LINES + V_FRONT_PORCH;
  localparam int unsigned VS_END   = VS_START + V_SYNC_WIDTH;

  if (TOTAL_PIXELS > 2048) begin : g_bad_pixels
    $fatal(1, "video_sig_gen: TOTAL_PIXELS exceeds 2048");
  end
  if (TOTAL_LINES > 1024) begin : g_bad_lines
    $fatal(1, "video_sig_gen: TOTAL_LINES exceeds 1024");
  end
  if (FPS > 64) begin : g_bad_fps
    $fatal(1, "video_sig_gen: FPS exceeds 64");
  end

  hcount_t h_next;
  vcount_t v_next;
  logic    h_wrap;
  logic    v_wrap;
  logic    nf_c;
  logic    fc_wrap_unused;

  wrap_counter #(.MAX(TOTAL_PIXELS), .WIDTH(HCOUNT_W)) u_hcount (
    .clk(pixel_clk_in), .rst_n(rst_n_in), .incr_in(1'b1),
    .count_out(hcount_out), .wrap_out(h_wrap)
  );

  wrap_counter #(.MAX(TOTAL_LINES), .WIDTH(VCOUNT_W)) u_vcount (
    .clk(pixel_clk_in), .rst_n(rst_n_in), .incr_in(h_wrap),
    .count_out(vcount_out), .wrap_out(v_wrap)
  );

  wrap_counter #(.MAX(FPS), .WIDTH(FC_W)) u_fcount (
    .clk(pixel_clk_in), .rst_n(rst_n_in), .incr_in(nf_c),
    .count_out(fc_out), .wrap_out(fc_wrap_unused)
  );

  // Next-state coordinates, so the registered flags line up with the registered counts.
  always_comb begin
    h_next = h_wrap ? '0 : hcount_out + hcount_t'(1);
    v_next = vcount_out;
    if (v_wrap) begin
      v_next = '0;
    end else if (h_wrap) begin
      v_next = vcount_out + vcount_t'(1);
    end
    nf_c = (h_next == hcount_t'(ACTIVE_H)) && (v_next == vcount_t'(ACTIVE_LINES));
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hs_out <= 1'b0;
      vs_out <= 1'b0;
      ad_out <= 1'b0;
      nf_out <= 1'b0;
    end else begin
      hs_out <= (h_next >= hcount_t'(HS_START)) && (h_next < hcount_t'(HS_END));
      vs_out <= (v_next >= vcount_t'(VS_START)) && (v_next < vcount_t'(VS_END));
      ad_out <= (h_next < hcount_t'(ACTIVE_H)) && (v_next < vcount_t'(ACTIVE_LINES));
      nf_out <= nf_c;
    end
  end

endmodule

// File: tb/tb_video_sig_gen.sv
// Bench: 720p instance checked against a table over its first lines; a shrunken-raster
// instance checked every cycle against an arithmetic model across 60+ frames and random resets.
module tb_video_sig_gen;

  localparam longint S_AH = 16, S_HFP = 3, S_HSW = 4, S_HBP = 5;
  localparam longint S_AL = 6, S_VFP = 2, S_VSW = 2, S_VBP = 3;
  localparam longint S_FPS   = 60;
  localparam longint S_TP    = S_AH + S_HFP + S_HSW + S_HBP;
  localparam longint S_TL    = S_AL + S_VFP + S_VSW + S_VBP;
  localparam longint S_FRAME = S_TP * S_TL;
  localparam longint S_NFPOS = S_AL * S_TP + S_AH;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        ad;
    logic        nf;
    logic [5:0]  fc;
  } obs_t;

  typedef struct {
    int unsigned n;
    obs_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_hd, rst_sm;
  logic [10:0] hd_h, sm_h;
  logic [9:0]  hd_v, sm_v;
  logic        hd_hs, hd_vs, hd_ad, hd_nf, sm_hs, sm_vs, sm_ad, sm_nf;
  logic [5:0]  hd_fc, sm_fc;

  int     checks = 0;
  int     passes = 0;
  longint n      = 0;
  int     nf_cnt = 0;

  always #5 clk = ~clk;

  video_sig_gen u_hd (
    .pixel_clk_in(clk), .rst_n_in(rst_hd),
    .hcount_out(hd_h), .vcount_out(hd_v), .hs_out(hd_hs), .vs_out(hd_vs),
    .ad_out(hd_ad), .nf_out(hd_nf), .fc_out(hd_fc)
  );

  video_sig_gen #(
    .ACTIVE_H(16), .H_FRONT_PORCH(3), .H_SYNC_WIDTH(4), .H_BACK_PORCH(5),
    .ACTIVE_LINES(6), .V_FRONT_PORCH(2), .V_SYNC_WIDTH(2), .V_BACK_PORCH(3), .FPS(60)
  ) u_sm (
    .pixel_clk_in(clk), .rst_n_in(rst_sm),
    .hcount_out(sm_h), .vcount_out(sm_v), .hs_out(sm_hs), .vs_out(sm_vs),
    .ad_out(sm_ad), .nf_out(sm_nf), .fc_out(sm_fc)
  );

  // Expected outputs k edges after reset release, from raster position arithmetic.
  function automatic obs_t model(input longint k);
    obs_t   o;
    longint pos = k % S_FRAME;
    longint h   = pos % S_TP;
    longint v   = pos / S_TP;
    o.h  = 11'(h);
    o.v  = 10'(v);
    o.hs = (h >= S_AH + S_HFP) && (h < S_AH + S_HFP + S_HSW);
    o.vs = (v >= S_AL + S_VFP) && (v < S_AL + S_VFP + S_VSW);
    o.ad = (k != 0) && (h < S_AH) && (v < S_AL);
    o.nf = (pos == S_NFPOS);
    o.fc = (k >= S_NFPOS) ? 6'(((k - S_NFPOS) / S_FRAME + 1) % S_FPS) : 6'd0;
    return o;
  endfunction

  function automatic obs_t hd_now();
    obs_t o;
    o.h = hd_h; o.v = hd_v; o.hs = hd_hs; o.vs = hd_vs;
    o.ad = hd_ad; o.nf = hd_nf; o.fc = hd_fc;
    return o;
  endfunction

  function automatic obs_t sm_now();
    obs_t o;
    o.h = sm_h; o.v = sm_v; o.hs = sm_hs; o.vs = sm_vs;
    o.ad = sm_ad; o.nf = sm_nf; o.fc = sm_fc;
    return o;
  endfunction

  function automatic vec_t mk(input int unsigned k, input int unsigned h, input int unsigned v,
                              input bit hs, input bit ad);
    vec_t r;
    r.n = k;
    r.exp = '0;
    r.exp.h  = 11'(h);
    r.exp.v  = 10'(v);
    r.exp.hs = hs;
    r.exp.ad = ad;
    return r;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("FAIL %s n=%0d got h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d exp h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d",
               name, n, got.h, got.v, got.hs, got.vs, got.ad, got.nf, got.fc,
               exp.h, exp.v, exp.hs, exp.vs, exp.ad, exp.nf, exp.fc);
    end
  endtask

  task automatic check_int(input string name, input longint got, input longint exp);
    checks++;
    if (got == exp) begin
      passes++;
    end else begin
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  // One small-instance edge: advance the model while out of reset, then compare.
  task automatic step_sm();
    @(posedge clk);
    #1;
    if (rst_sm) n++;
    if (sm_nf) nf_cnt++;
    check("sm_cycle", sm_now(), model(n));
  endtask

  initial begin
    vec_t   tbl[$];
    longint nh;
    int     hs_cnt;

    tbl.push_back(mk(0,    0,    0, 0, 0));
    tbl.push_back(mk(1,    1,    0, 0, 1));
    tbl.push_back(mk(2,    2,    0, 0, 1));
    tbl.push_back(mk(1279, 1279, 0, 0, 1));
    tbl.push_back(mk(1280, 1280, 0, 0, 0));
    tbl.push_back(mk(1389, 1389, 0, 0, 0));
    tbl.push_back(mk(1390, 1390, 0, 1, 0));
    tbl.push_back(mk(1429, 1429, 0, 1, 0));
    tbl.push_back(mk(1430, 1430, 0, 0, 0));
    tbl.push_back(mk(1649, 1649, 0, 0, 0));
    tbl.push_back(mk(1650, 0,    1, 0, 1));
    tbl.push_back(mk(1651, 1,    1, 0, 1));

    rst_hd = 1'b0;
    rst_sm = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 720p instance: first line and the wrap into line 1.
    check("hd_reset", hd_now(), tbl[0].exp);
    rst_hd = 1'b1;
    nh     = 0;
    hs_cnt = 0;
    for (int i = 1; i < tbl.size(); i++) begin
      while (nh < longint'(tbl[i].n)) begin
        @(posedge clk);
        #1;
        nh++;
        if (nh < 1650 && hd_hs) hs_cnt++;
      end
      check($sformatf("hd_edge%0d", tbl[i].n), hd_now(), tbl[i].exp);
    end
    check_int("hd_hs_width", hs_cnt, 40);
    #2;
    rst_hd = 1'b0;
    #1;
    check("hd_async_reset", hd_now(), tbl[0].exp);

    // Shrunken raster: 61 frames continuous, covering the frame-counter wrap.
    check("sm_reset", sm_now(), model(0));
    n      = 0;
    nf_cnt = 0;
    rst_sm = 1'b1;
    repeat (int'(61 * S_FRAME + 5)) step_sm();
    check_int("sm_nf_count", nf_cnt, 61);

    // Mid-frame asynchronous reset, then no strobe before the new frame's blanking start.
    for (int i = 0; i < int'(S_FRAME) && (n % S_FRAME) != 4 * S_TP + 10; i++) step_sm();
    check_int("sm_at_10_4", longint'(sm_h) + 1000 * longint'(sm_v), 4010);
    #2;
    rst_sm = 1'b0;
    n      = 0;
    #1;
    check("sm_async_reset", sm_now(), model(0));
    repeat (2) step_sm();
    #1;
    rst_sm = 1'b1;
    nf_cnt = 0;
    repeat (int'(S_NFPOS - 1)) step_sm();
    check_int("sm_no_early_nf", nf_cnt, 0);
    step_sm();
    check_int("sm_first_nf", longint'(sm_nf), 1);
    check_int("sm_first_fc", longint'(sm_fc), 1);

    // Random run lengths with resets landing at random points between edges.
    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(1, int'(2 * S_FRAME))) step_sm();
      #($urandom_range(1, 3));
      rst_sm = 1'b0;
      n      = 0;
      #1;
      check("sm_rand_reset", sm_now(), model(0));
      repeat ($urandom_range(0, 2)) step_sm();
      #($urandom_range(1, 3));
      rst_sm = 1'b1;
    end
    repeat (int'(S_FRAME)) step_sm();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
